// File: rtl/tft_bus_sequencer_if.sv
// Host, fill and LCD pin bundle for tft_bus_sequencer.
// The sequencer connects through the slave modport and its driver through the master modport.
interface tft_bus_sequencer_if #(
    parameter int CNT_W = 24
);
    logic             host_wr;
    logic [15:0]      host_data;
    logic             fifo_full;
    logic             ovf;
    logic             fill_start;
    logic [15:0]      fill_color;
    logic [CNT_W-1:0] fill_count;
    logic             fill_busy;
    logic             busy;
    logic             lcd_cs_n;
    logic             lcd_rs;
    logic             lcd_wr_n;
    logic [15:0]      lcd_data;
    logic             lcd_data_oe;

    modport master (
        output host_wr, host_data, fill_start, fill_color, fill_count,
        input  fifo_full, ovf, fill_busy, busy,
        input  lcd_cs_n, lcd_rs, lcd_wr_n, lcd_data, lcd_data_oe
    );

    modport slave (
        input  host_wr, host_data, fill_start, fill_color, fill_count,
        output fifo_full, ovf, fill_busy, busy,
        output lcd_cs_n, lcd_rs, lcd_wr_n, lcd_data, lcd_data_oe
    );
endinterface

// File: rtl/tft_bus_sequencer.sv
// 8080-style LCD write sequencer: tagged host words pass through a show-ahead FIFO,
// and a solid-colour fill engine shares the bus once the words queued ahead of it drain.
module tft_bus_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int T_SETUP    = 1,
    parameter int T_STROBE   = 2,
    parameter int T_HOLD     = 1,
    parameter int CNT_W      = 24
) (
    input logic                clk_i,
    input logic                rst_ni,
    tft_bus_sequencer_if.slave bus
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = AW + 1;
    localparam int TMR_MAX = (T_SETUP > T_STROBE) ?
                             ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD) :
                             ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_e;

    // Returns {rs, data} for a tagged host word.
    function automatic logic [16:0] decode_word(input logic [15:0] w);
        logic [16:0] r;
        if (!w[15]) begin
            r = {1'b0, w};
        end else if (!w[14]) begin
            r = {2'b10, w[14:0]};
        end else begin
            r = {1'b1, w[13:10], w[10:5], w[5:0]};
        end
        return r;
    endfunction

    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ovf_q;

    logic             fill_busy_q;
    logic [OCC_W-1:0] ahead_q;
    logic [CNT_W-1:0] fcnt_q;
    logic [15:0]      fcolor_q;

    state_e           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic             cs_n_q, wr_n_q, rs_q, oe_q;
    logic [15:0]      data_q;

    logic full, empty, push, pop;
    logic hold_end, issue_slot, fifo_ok, fill_ok;
    logic issue_fifo, issue_fill, issue, fill_acc, fill_done;
    logic [16:0] word;

    assign full  = (occ_q == OCC_W'(FIFO_DEPTH));
    assign empty = (occ_q == '0);
    // A write into a full FIFO is dropped even if a pop happens on the same edge.
    assign push  = bus.host_wr && !full;
    assign pop   = issue_fifo;

    assign hold_end   = (state_q == S_HOLD) && (tmr_q == '0);
    assign issue_slot = (state_q == S_IDLE) || hold_end;
    assign fifo_ok    = !empty && (!fill_busy_q || (ahead_q != '0));
    assign fill_ok    = fill_busy_q && (ahead_q == '0) && (fcnt_q != '0);
    assign issue_fifo = issue_slot && fifo_ok;
    assign issue_fill = issue_slot && fill_ok;
    assign issue      = issue_fifo || issue_fill;

    assign fill_acc  = bus.fill_start && !fill_busy_q && (bus.fill_count != '0);
    assign fill_done = hold_end && fill_busy_q && (ahead_q == '0) && (fcnt_q == '0);

    assign word = issue_fill ? {1'b1, fcolor_q} : decode_word(mem_q[rptr_q]);

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= bus.host_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            occ_q <= occ_d;
            if (bus.host_wr && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_acc) begin
            fcolor_q <= bus.fill_color;
        end
    end

    // Words already queued (including one pushed on the accept edge) go out before the fill.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fill_busy_q <= 1'b0;
            ahead_q     <= '0;
            fcnt_q      <= '0;
        end else if (fill_acc) begin
            fill_busy_q <= 1'b1;
            ahead_q     <= occ_d;
            fcnt_q      <= bus.fill_count;
        end else begin
            if (fill_done) begin
                fill_busy_q <= 1'b0;
            end
            if (issue_fifo && fill_busy_q && (ahead_q != '0)) begin
                ahead_q <= ahead_q - OCC_W'(1);
            end
            if (issue_fill && (fcnt_q != '0)) begin
                fcnt_q <= fcnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rs_q    <= 1'b1;
            oe_q    <= 1'b0;
            data_q  <= '0;
        end else if (issue) begin
            state_q <= S_SETUP;
            tmr_q   <= TMR_W'(T_SETUP - 1);
            cs_n_q  <= 1'b0;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b1;
            rs_q    <= word[16];
            data_q  <= word[15:0];
        end else begin
            case (state_q)
                S_SETUP: begin
                    if (tmr_q == '0) begin
                        state_q <= S_STROBE;
                        tmr_q   <= TMR_W'(T_STROBE - 1);
                        wr_n_q  <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                S_STROBE: begin
                    if (tmr_q == '0) begin
                        state_q <= S_HOLD;
                        tmr_q   <= TMR_W'(T_HOLD - 1);
                        wr_n_q  <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                S_HOLD: begin
                    if (tmr_q == '0) begin
                        state_q <= S_IDLE;
                        cs_n_q  <= 1'b1;
                        oe_q    <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_full   = full;
    assign bus.ovf         = ovf_q;
    assign bus.fill_busy   = fill_busy_q;
    assign bus.busy        = (state_q != S_IDLE) || !empty || fill_busy_q;
    assign bus.lcd_cs_n    = cs_n_q;
    assign bus.lcd_rs      = rs_q;
    assign bus.lcd_wr_n    = wr_n_q;
    assign bus.lcd_data    = data_q;
    assign bus.lcd_data_oe = oe_q;
endmodule

// File: tb/tb_tft_bus_sequencer.sv
// Bench for tft_bus_sequencer: scenario tasks compare bus writes against a queue-based
// model of tag decoding, fill ordering and FIFO overflow.
module tb_tft_bus_sequencer;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 24;
    localparam int WORD_CYC   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];
    logic        mon_wr_prev = 1'b1;

    tft_bus_sequencer_if #(.CNT_W(CNT_W)) bus ();

    tft_bus_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH), .T_SETUP(1), .T_STROBE(2), .T_HOLD(1), .CNT_W(CNT_W)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Bus monitor: the LCD latches on the rising edge of WR_N while selected.
    always @(negedge clk) begin
        if (mon_wr_prev === 1'b0 && bus.lcd_wr_n === 1'b1 && bus.lcd_cs_n === 1'b0)
            got_q.push_back({bus.lcd_rs, bus.lcd_data});
        mon_wr_prev <= bus.lcd_wr_n;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference decode: {rs, data} from the tag rules using plain arithmetic.
    function automatic logic [16:0] model_word(input logic [15:0] w);
        int wi, r, g, b;
        wi = int'(w);
        if (wi < 32768) return {1'b0, w};
        if (wi < 49152) return {1'b1, 16'(wi - 32768)};
        r = (wi >> 10) & 15;
        g = (wi >> 5) & 63;
        b = wi & 63;
        return {1'b1, 16'((r << 12) + (g << 6) + b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests++;
        if ({bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rs, bus.lcd_data_oe} !== 4'b1110) begin
            fails++;
            $display("FAIL reset_pins got %b want 1110",
                     {bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rs, bus.lcd_data_oe});
        end
        tests++;
        if (bus.lcd_data !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data got %h want 0000", bus.lcd_data);
        end
        tests++;
        if ({bus.fifo_full, bus.ovf, bus.fill_busy, bus.busy} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_status got %b want 0000",
                     {bus.fifo_full, bus.ovf, bus.fill_busy, bus.busy});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_cmd();
        bit found = 1'b0;
        bit ok;
        logic [4:0] cs_pat = '0, wr_pat = '0, oe_pat = '0;
        logic [16:0] first = '0;
        logic [15:0] last_data = '0;
        got_q.delete();
        bus.host_wr = 1'b1;
        bus.host_data = 16'h0022;
        tick();
        bus.host_wr = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (bus.lcd_cs_n === 1'b0) found = 1'b1;
            else tick();
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL single_cs_fall got none want cs_n low");
        end
        for (int i = 0; i < 5; i++) begin
            cs_pat = {cs_pat[3:0], bus.lcd_cs_n};
            wr_pat = {wr_pat[3:0], bus.lcd_wr_n};
            oe_pat = {oe_pat[3:0], bus.lcd_data_oe};
            if (i == 0) first = {bus.lcd_rs, bus.lcd_data};
            if (i == 4) last_data = bus.lcd_data;
            tick();
        end
        tests++;
        if (cs_pat !== 5'b00001) begin
            fails++;
            $display("FAIL single_cs_pattern got %b want 00001", cs_pat);
        end
        tests++;
        if (wr_pat !== 5'b10011) begin
            fails++;
            $display("FAIL single_wr_pattern got %b want 10011", wr_pat);
        end
        tests++;
        if (oe_pat !== 5'b11110) begin
            fails++;
            $display("FAIL single_oe_pattern got %b want 11110", oe_pat);
        end
        tests++;
        if (first !== model_word(16'h0022)) begin
            fails++;
            $display("FAIL single_rs_data got %h want %h", first, model_word(16'h0022));
        end
        tests++;
        if (last_data !== 16'h0022) begin
            fails++;
            $display("FAIL single_data_kept got %h want 0022", last_data);
        end
        wait_idle(50, ok);
        tests++;
        if (!ok || got_q.size() != 1) begin
            fails++;
            $display("FAIL single_count got %0d want 1 (idle=%0d)", got_q.size(), ok);
        end
    endtask

    task automatic test_back_to_back();
        bit found = 1'b0;
        bit ok;
        int low = 0;
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(model_word(16'h8123));
        exp_q.push_back(model_word(16'hC7FF));
        bus.host_wr = 1'b1;
        bus.host_data = 16'h8123;
        tick();
        bus.host_data = 16'hC7FF;
        tick();
        bus.host_wr = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (bus.lcd_cs_n === 1'b0) found = 1'b1;
            else tick();
        end
        for (int i = 0; i < 20 && bus.lcd_cs_n === 1'b0; i++) begin
            low++;
            tick();
        end
        tests++;
        if (low != 2 * WORD_CYC) begin
            fails++;
            $display("FAIL b2b_cs_low_cycles got %0d want %0d", low, 2 * WORD_CYC);
        end
        wait_idle(50, ok);
        tests++;
        if (!ok || got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL b2b_word%0d got %h want %h", i,
                         (i < got_q.size()) ? got_q[i] : 17'bx, exp_q[i]);
            end
        end
    endtask

    task automatic test_fill_arbitration();
        bit ok = 1'b0;
        bit idle_ok;
        bit early_drop = 1'b0;
        int nfill = 0;
        logic prev;
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(model_word(16'h002A));
        exp_q.push_back(model_word(16'h002B));
        for (int k = 0; k < 5; k++) exp_q.push_back({1'b1, 16'hF800});
        exp_q.push_back(model_word(16'h0022));
        bus.host_wr = 1'b1;
        bus.host_data = 16'h002A;
        tick();
        bus.host_data = 16'h002B;
        tick();
        bus.host_wr = 1'b0;
        bus.fill_start = 1'b1;
        bus.fill_count = 24'd5;
        bus.fill_color = 16'hF800;
        tick();
        bus.fill_start = 1'b0;
        tests++;
        if (bus.fill_busy !== 1'b1) begin
            fails++;
            $display("FAIL fill_busy_rise got %b want 1", bus.fill_busy);
        end
        tick();
        tick();
        bus.host_wr = 1'b1;
        bus.host_data = 16'h0022;
        tick();
        bus.host_wr = 1'b0;
        prev = bus.lcd_wr_n;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (prev === 1'b0 && bus.lcd_wr_n === 1'b1 && bus.lcd_rs === 1'b1 &&
                bus.lcd_data === 16'hF800) nfill++;
            prev = bus.lcd_wr_n;
            if (nfill == 5) begin
                ok = 1'b1;
                break;
            end
            if (bus.fill_busy !== 1'b1) early_drop = 1'b1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL fill_words_seen got %0d want 5", nfill);
        end
        tests++;
        if (early_drop) begin
            fails++;
            $display("FAIL fill_busy_early_drop got 0 want 1 during fill");
        end
        tests++;
        if (bus.fill_busy !== 1'b1) begin
            fails++;
            $display("FAIL fill_busy_last_hold got %b want 1", bus.fill_busy);
        end
        tick();
        tests++;
        if (bus.fill_busy !== 1'b0) begin
            fails++;
            $display("FAIL fill_busy_fall got %b want 0", bus.fill_busy);
        end
        wait_idle(100, idle_ok);
        tests++;
        if (!idle_ok || got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL arb_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL arb_word%0d got %h want %h", i,
                         (i < got_q.size()) ? got_q[i] : 17'bx, exp_q[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [15:0] cmd, col;
        int cnt;
        cmd = 16'($urandom) & 16'h7FFF;
        col = 16'($urandom);
        cnt = $urandom_range(1, 4);
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(model_word(cmd));
        for (int k = 0; k < cnt; k++) exp_q.push_back({1'b1, col});
        bus.host_wr = 1'b1;
        bus.host_data = cmd;
        bus.fill_start = 1'b1;
        bus.fill_count = 24'(cnt);
        bus.fill_color = col;
        tick();
        bus.host_wr = 1'b0;
        bus.fill_start = 1'b0;
        wait_idle(100, ok);
        tests++;
        if (!ok || got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL simul_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL simul_word%0d got %h want %h", i,
                         (i < got_q.size()) ? got_q[i] : 17'bx, exp_q[i]);
            end
        end
    endtask

    task automatic test_fill_ignored();
        got_q.delete();
        bus.fill_start = 1'b1;
        bus.fill_count = '0;
        bus.fill_color = 16'h1234;
        tick();
        bus.fill_start = 1'b0;
        tests++;
        if ({bus.fill_busy, bus.busy} !== 2'b00) begin
            fails++;
            $display("FAIL zero_fill_busy got %b want 00", {bus.fill_busy, bus.busy});
        end
        repeat (10) tick();
        tests++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL zero_fill_writes got %0d want 0", got_q.size());
        end
    endtask

    task automatic test_random();
        logic [15:0] words[8];
        logic [15:0] col, col2;
        int nh, p, cnt, cnt2;
        bit ok;
        for (int r = 0; r < 4; r++) begin
            nh   = $urandom_range(1, 6);
            p    = $urandom_range(0, nh);
            cnt  = $urandom_range(1, 6);
            cnt2 = $urandom_range(1, 6);
            col  = 16'($urandom);
            col2 = 16'($urandom);
            for (int i = 0; i < nh; i++) words[i] = 16'($urandom);
            got_q.delete();
            exp_q.delete();
            for (int i = 0; i < nh; i++) if (i <= p) exp_q.push_back(model_word(words[i]));
            for (int k = 0; k < cnt; k++) exp_q.push_back({1'b1, col});
            for (int i = 0; i < nh; i++) if (i > p) exp_q.push_back(model_word(words[i]));
            for (int i = 0; i <= nh + 1; i++) begin
                bus.host_wr    = (i < nh);
                bus.host_data  = (i < nh) ? words[i] : 16'h0000;
                bus.fill_start = (i == p) || (i == p + 1);
                bus.fill_count = (i == p) ? 24'(cnt) : 24'(cnt2);
                bus.fill_color = (i == p) ? col : col2;
                tick();
            end
            bus.host_wr = 1'b0;
            bus.fill_start = 1'b0;
            wait_idle(300, ok);
            tests++;
            if (!ok || got_q.size() != exp_q.size()) begin
                fails++;
                $display("FAIL rand%0d_count got %0d want %0d", r, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL rand%0d_word%0d got %h want %h", r, i,
                             (i < got_q.size()) ? got_q[i] : 17'bx, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] words[24];
        bit acc[24];
        int occ = 0;
        bit pop_now, ok;
        bit seen_full = 1'b0;
        bit dropped_yet = 1'b0;
        bit ovf_early = 1'b0;
        for (int k = 0; k < 24; k++) words[k] = 16'($urandom);
        // Occupancy model: one pop per word time, the first one edge after the first push.
        got_q.delete();
        exp_q.delete();
        for (int k = 0; k < 24; k++) begin
            acc[k]  = (occ < FIFO_DEPTH);
            pop_now = ((k % WORD_CYC) == 1) && (occ > 0);
            occ     = occ + (acc[k] ? 1 : 0) - (pop_now ? 1 : 0);
            bus.host_wr = 1'b1;
            bus.host_data = words[k];
            tick();
            if (!acc[k]) dropped_yet = 1'b1;
            if (bus.fifo_full === 1'b1) seen_full = 1'b1;
            if (!dropped_yet && bus.ovf !== 1'b0) ovf_early = 1'b1;
            tests++;
            if (bus.fifo_full !== (occ == FIFO_DEPTH)) begin
                fails++;
                $display("FAIL ovf_full_cycle%0d got %b want %b", k, bus.fifo_full,
                         (occ == FIFO_DEPTH));
            end
            if (acc[k]) exp_q.push_back(model_word(words[k]));
        end
        bus.host_wr = 1'b0;
        tests++;
        if (!seen_full || bus.ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_flags got full_seen=%0d ovf=%b want 1 1", seen_full, bus.ovf);
        end
        tests++;
        if (ovf_early) begin
            fails++;
            $display("FAIL ovf_early got 1 want 0 before first drop");
        end
        wait_idle(400, ok);
        tests++;
        if (!ok || got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL ovf_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL ovf_word%0d got %h want %h", i,
                         (i < got_q.size()) ? got_q[i] : 17'bx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        bit found = 1'b0;
        bit cs_fell = 1'b0;
        bus.fill_start = 1'b1;
        bus.fill_count = 24'd10;
        bus.fill_color = 16'($urandom);
        tick();
        bus.fill_start = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.lcd_wr_n === 1'b0) found = 1'b1;
            else tick();
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL rst_strobe_seen got none want wr_n low");
        end
        rst_n = 1'b0;
        tick();
        tests++;
        if ({bus.lcd_wr_n, bus.lcd_cs_n, bus.lcd_data_oe, bus.fill_busy} !== 4'b1100) begin
            fails++;
            $display("FAIL rst_mid_pins got %b want 1100",
                     {bus.lcd_wr_n, bus.lcd_cs_n, bus.lcd_data_oe, bus.fill_busy});
        end
        tests++;
        if ({bus.busy, bus.ovf, bus.fifo_full, bus.lcd_rs, bus.lcd_data} !== {4'b0001, 16'h0000}) begin
            fails++;
            $display("FAIL rst_mid_status got %b_%h want 0001_0000",
                     {bus.busy, bus.ovf, bus.fifo_full, bus.lcd_rs}, bus.lcd_data);
        end
        rst_n = 1'b1;
        got_q.delete();
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.lcd_cs_n !== 1'b1) cs_fell = 1'b1;
        end
        tests++;
        if (got_q.size() != 0 || cs_fell) begin
            fails++;
            $display("FAIL rst_no_writes got %0d writes cs_fell=%0d want 0 0", got_q.size(), cs_fell);
        end
    endtask

    initial begin
        bus.host_wr    = 1'b0;
        bus.host_data  = '0;
        bus.fill_start = 1'b0;
        bus.fill_color = '0;
        bus.fill_count = '0;
        test_reset();
        test_single_cmd();
        test_back_to_back();
        test_fill_arbitration();
        test_simultaneous();
        test_fill_ignored();
        test_random();
        test_overflow();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
